frame_stream_reader: RTL and testbench

//  Reads a downscaled 8-bit grayscale frame out of the frame RAM that the scaler writes (wa/write_signal side)
//  and replays it as a raster stream (VSYNC/HSYNC/DE/DOUT) in the same signalling style the image reader uses.

---
 rtl/video_pkg.sv | 26 ++
 rtl/frame_stream_reader_raster_counter.sv | 56 +++++
 rtl/frame_stream_reader.sv | 121 ++++++++++++
 tb/tb_frame_stream_reader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: FSM state encoding and default frame geometry
// used by the scaler, the frame writer and the frame stream reader.
package video_pkg;

  // Source and downscaled frame geometry.
  localparam int SRC_H       = 1920;
  localparam int SRC_V       = 1080;
  localparam int DST_H       = 960;
  localparam int DST_V       = 540;
  localparam int FRAME_WORDS = DST_H * DST_V;

  // Raster replay FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VS     = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_DONE   = 3'd4
  } fsm_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_stream_reader_raster_counter.sv
// Column / blank / row counters for the raster replay. Advances the column
// while the FSM is in ACTIVE and the blank counter while in HBLANK, and
// raises end-of-line, first/last blank cycle and last-row flags.
module raster_counter
  import video_pkg::*;
#(
  parameter int H_PIXELS = DST_H,
  parameter int V_PIXELS = DST_V,
  parameter int H_BLANK  = 160
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic act,
  input  logic blk,
  output logic line_end,
  output logic blank_first,
  output logic blank_end,
  output logic last_row
);

  localparam int CW = cnt_w(H_PIXELS);
  localparam int RW = cnt_w(V_PIXELS);
  localparam int BW = cnt_w(H_BLANK);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [BW-1:0] bcnt;

  assign line_end    = (col == CW'(H_PIXELS - 1));
  assign blank_first = (bcnt == '0);
  assign blank_end   = (bcnt == BW'(H_BLANK - 1));
  assign last_row    = (row == RW'(V_PIXELS - 1));

  // Step column in ACTIVE, blank count and row in HBLANK; clear while idle.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst || clr) begin
      col  <= '0;
      row  <= '0;
      bcnt <= '0;
    end else begin
      if (act) begin
        col <= line_end ? '0 : col + 1'b1;
      end
      if (blk) begin
        bcnt <= blank_end ? '0 : bcnt + 1'b1;
        if (blank_end && !last_row) begin
          row <= row + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/frame_stream_reader.sv
// Replays one downscaled frame from the scaler RAM as a VSYNC/HSYNC/DE/DOUT
// raster stream per start pulse. RAM reads are issued in ACTIVE; the stream
// outputs lag the FSM by one cycle so DE lines up with the RAM read data.
module frame_stream_reader
  import video_pkg::*;
#(
  parameter int H_PIXELS = DST_H,
  parameter int V_PIXELS = DST_V,
  parameter int H_BLANK  = 160,
  parameter int VS_CYC   = 100,
  parameter int ADDR_W   = 19
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  input  logic [7:0]        ram_data,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic              DE,
  output logic [7:0]        DOUT,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] VS     = ST_VS;
  localparam logic [2:0] ACTIVE = ST_ACTIVE;
  localparam logic [2:0] HBLANK = ST_HBLANK;
  localparam logic [2:0] DONE   = ST_DONE;

  localparam int VW = cnt_w(VS_CYC);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [ADDR_W-1:0] addr;
  logic [VW-1:0]     vcnt;
  logic              vs_end;
  logic              line_end;
  logic              blank_first;
  logic              blank_end;
  logic              last_row;

  assign vs_end = (vcnt == VW'(VS_CYC - 1));

  raster_counter #(
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS),
    .H_BLANK  (H_BLANK)
  ) u_raster (
    .clk         (HCLK),
    .rst         (HRESET),
    .clr         (state == IDLE),
    .act         (state == ACTIVE),
    .blk         (state == HBLANK),
    .line_end    (line_end),
    .blank_first (blank_first),
    .blank_end   (blank_end),
    .last_row    (last_row)
  );

  // Next-state decode of the raster FSM.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch forms.
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = VS;
      VS:      if (vs_end) next_state = ACTIVE;
      ACTIVE:  if (line_end) next_state = HBLANK;
      HBLANK:  if (blank_end) next_state = last_row ? DONE : ACTIVE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM state, busy flag, vsync counter and running RAM address.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
      busy  <= 1'b0;
      addr  <= '0;
      vcnt  <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      case (state)
        IDLE: begin
          addr <= '0;
          vcnt <= '0;
        end
        VS:      vcnt <= vcnt + 1'b1;
        ACTIVE:  addr <= addr + 1'b1;
        default: ;
      endcase
    end
  end

  // Reads go out in the same cycle the FSM sits in ACTIVE.
  assign ram_addr = addr;
  assign ram_re   = (state == ACTIVE);

  // Stream flags are the FSM decode delayed one cycle to match RAM latency.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      VSYNC      <= 1'b0;
      HSYNC      <= 1'b0;
      DE         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      VSYNC      <= (state == VS);
      HSYNC      <= (state == HBLANK) && blank_first;
      DE         <= (state == ACTIVE);
      frame_done <= (state == DONE);
    end
  end

  // The RAM read data register is the pixel register; DE gates it to zero.
  assign DOUT = DE ? ram_data : 8'h00;

endmodule

// File: tb/tb_frame_stream_reader.sv
// Directed bench for frame_stream_reader in a 4x2 configuration. Expected
// pixels are queued when a start is driven and popped whenever DE is seen.
module tb_frame_stream_reader;

  localparam int H_PIXELS = 4;
  localparam int V_PIXELS = 2;
  localparam int H_BLANK  = 2;
  localparam int VS_CYC   = 3;
  localparam int ADDR_W   = 3;
  localparam int NPIX     = H_PIXELS * V_PIXELS;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              start;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic [7:0]        ram_data = 8'h00;
  logic              VSYNC;
  logic              HSYNC;
  logic              DE;
  logic [7:0]        DOUT;
  logic              busy;
  logic              frame_done;

  frame_stream_reader #(
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS),
    .H_BLANK  (H_BLANK),
    .VS_CYC   (VS_CYC),
    .ADDR_W   (ADDR_W)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .start      (start),
    .ram_addr   (ram_addr),
    .ram_re     (ram_re),
    .ram_data   (ram_data),
    .VSYNC      (VSYNC),
    .HSYNC      (HSYNC),
    .DE         (DE),
    .DOUT       (DOUT),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 HCLK = ~HCLK;

  // Frame RAM model: one-cycle registered read, RAM[i] = 8'h10 + i.
  always @(posedge HCLK) begin
    if (ram_re) ram_data <= 8'h10 + 8'(ram_addr);
  end

  int total  = 0;
  int passed = 0;

  logic [7:0] exp_q[$];
  int exp_addr = 0;
  logic prev_re = 1'b0;
  logic prev_vs = 1'b0;
  int vs_cnt = 0, hs_cnt = 0, de_cnt = 0, fd_cnt = 0, busy_cnt = 0, re_cnt = 0;
  int b_vs, b_hs, b_de, b_fd, b_busy, b_re;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic monitor(input logic rst_was);
    logic [7:0] e;
    if (rst_was) begin
      check("rst_outs", {ram_addr, ram_re, VSYNC, HSYNC, DE, DOUT, busy, frame_done}, 0);
      prev_re  = 1'b0;
      prev_vs  = 1'b0;
      exp_addr = 0;
    end else begin
      check("de_align", DE, prev_re);
      if (DE) begin
        if (exp_q.size() == 0) check("de_unexpected", DE, 0);
        else begin
          e = exp_q.pop_front();
          check("dout", DOUT, e);
        end
      end else begin
        check("dout_zero", DOUT, 0);
      end
      if (VSYNC && !prev_vs) exp_addr = 0;
      if (ram_re) begin
        check("ram_addr", ram_addr, exp_addr);
        check("re_busy", busy, 1);
        exp_addr++;
      end
      vs_cnt   += int'(VSYNC);
      hs_cnt   += int'(HSYNC);
      de_cnt   += int'(DE);
      fd_cnt   += int'(frame_done);
      busy_cnt += int'(busy);
      re_cnt   += int'(ram_re);
      prev_re = ram_re;
      prev_vs = VSYNC;
    end
  endtask

  // Advance one clock; sample on the falling edge.
  task automatic tick();
    logic rst_was;
    rst_was = HRESET;
    @(posedge HCLK);
    @(negedge HCLK);
    monitor(rst_was);
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) exp_q.push_back(8'(8'h10 + i));
  endtask

  task automatic snap();
    b_vs = vs_cnt; b_hs = hs_cnt; b_de = de_cnt;
    b_fd = fd_cnt; b_busy = busy_cnt; b_re = re_cnt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first_vs, first_de, first_hs, first_fd, fd_tick;

    // Reset with start held high: start must be ignored.
    HRESET = 1'b1;
    start  = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
    start  = 1'b0;
    tick();
    tick();
    check("idle_busy", busy, 0);
    check("idle_vsync", VSYNC, 0);

    // Full frame with latency of each stream event.
    snap();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    check("busy_lat", busy, 1);
    check("vsync_lat", VSYNC, 0);
    first_vs = 0; first_de = 0; first_hs = 0; first_fd = 0;
    for (int n = 2; n <= 20; n++) begin
      tick();
      if (VSYNC && first_vs == 0) first_vs = n;
      if (DE && first_de == 0) first_de = n;
      if (HSYNC && first_hs == 0) first_hs = n;
      if (frame_done && first_fd == 0) first_fd = n;
    end
    check("first_vsync", first_vs, 2);
    check("first_de", first_de, 5);
    check("first_hsync", first_hs, 9);
    check("first_fdone", first_fd, 17);
    check("vs_cycles", vs_cnt - b_vs, VS_CYC);
    check("hs_pulses", hs_cnt - b_hs, V_PIXELS);
    check("de_cycles", de_cnt - b_de, NPIX);
    check("re_cycles", re_cnt - b_re, NPIX);
    check("fd_pulses", fd_cnt - b_fd, 1);
    check("busy_cycles", busy_cnt - b_busy, 16);
    check("q_empty", exp_q.size(), 0);

    // Start pulses mid-line and in DONE are ignored.
    snap();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    run(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    run(9);
    start = 1'b1;
    tick();
    start = 1'b0;
    run(12);
    check("busy_vs", vs_cnt - b_vs, VS_CYC);
    check("busy_de", de_cnt - b_de, NPIX);
    check("busy_fd", fd_cnt - b_fd, 1);
    check("busy_len", busy_cnt - b_busy, 16);
    check("busy_idle", busy, 0);
    check("busy_q", exp_q.size(), 0);

    // Reset during line 1 pixel 2 aborts the frame.
    snap();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    run(11);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    exp_q.delete();
    run(6);
    check("abort_fd", fd_cnt - b_fd, 0);
    check("abort_busy", busy, 0);
    snap();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    run(19);
    check("replay_de", de_cnt - b_de, NPIX);
    check("replay_fd", fd_cnt - b_fd, 1);
    check("replay_q", exp_q.size(), 0);

    // Back-to-back: restart the cycle frame_done is seen.
    snap();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    fd_tick = 0;
    for (int n = 2; n <= 40 && fd_tick == 0; n++) begin
      tick();
      if (frame_done) fd_tick = n;
    end
    check("b2b_fd_tick", fd_tick, 17);
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    run(19);
    check("b2b_vs", vs_cnt - b_vs, 2 * VS_CYC);
    check("b2b_hs", hs_cnt - b_hs, 2 * V_PIXELS);
    check("b2b_de", de_cnt - b_de, 2 * NPIX);
    check("b2b_fd", fd_cnt - b_fd, 2);
    check("b2b_busy_len", busy_cnt - b_busy, 32);
    check("b2b_q", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
